// File: rtl/rom_dl_arbiter.sv
// ----------------------------------------------------------------------------
// rom_dl_arbiter : shares the ROM RAM port between HPS download writes and
//                  CPU/video reads, and sequences core reset around a download.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rom_dl_arbiter #(
  parameter int            AW          = 16,
  parameter int            HOLD_CYCLES = 1024,
  parameter logic [AW-1:0] ROM_TOP     = 16'hBFFF
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          dn_download,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic [7:0]    dn_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic [7:0]    cpu_data,
  output logic          cpu_valid,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          core_reset,
  output logic          dl_overflow
);

  localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            core_reset_q, core_reset_d;
  logic            ovf_q, ovf_d;
  logic            buf_valid_q, buf_valid_d;
  logic [AW-1:0]   buf_addr_q, buf_addr_d;
  logic [7:0]      buf_data_q, buf_data_d;
  logic            rd_pend_q, rd_pend_d;
  logic            cpu_valid_q, cpu_valid_d;
  logic [7:0]      cpu_data_q, cpu_data_d;

  logic            wr_window;
  logic            wr_cand;
  logic            drain;
  logic            wr_accept;
  logic            wr_drop;

  // A read always owns the port; the buffered write drains on any cycle without one.
  assign wr_window = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign wr_cand   = dn_wr && wr_window && (dn_addr <= ROM_TOP);
  assign drain     = buf_valid_q && !cpu_req;
  assign wr_accept = wr_cand && (!buf_valid_q || drain);
  assign wr_drop   = wr_cand && !wr_accept;

  always_comb begin
    ram_addr = buf_addr_q;
    ram_din  = buf_data_q;
    ram_we   = 1'b0;
    if (cpu_req) begin
      ram_addr = cpu_addr;
    end else if (buf_valid_q) begin
      ram_we = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dn_download) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      S_LOAD: begin
        if (!dn_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!buf_valid_q && !wr_accept) begin
          state_d = S_HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      S_HOLD: begin
        if (dn_download) begin
          state_d = S_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (dn_download) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    core_reset_d = (state_d != S_RUN);

    if ((state_d == S_LOAD) && (state_q != S_LOAD)) ovf_d = 1'b0;
    else                                            ovf_d = ovf_q | wr_drop;

    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (wr_accept) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = dn_addr;
      buf_data_d  = dn_data;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end

    // RAM answers one cycle after the address; the result is registered once more.
    rd_pend_d   = cpu_req;
    cpu_valid_d = rd_pend_q;
    cpu_data_d  = rd_pend_q ? ram_dout : cpu_data_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      ovf_q        <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= 8'h00;
      rd_pend_q    <= 1'b0;
      cpu_valid_q  <= 1'b0;
      cpu_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      ovf_q        <= ovf_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      rd_pend_q    <= rd_pend_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_data_q   <= cpu_data_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign dl_overflow = ovf_q;
  assign cpu_valid   = cpu_valid_q;
  assign cpu_data    = cpu_data_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_dl_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rom_dl_arbiter : directed + randomized bench for rom_dl_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rom_dl_arbiter;
  localparam int          H   = 64;
  localparam logic [15:0] TOP = 16'hBFFF;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = 16'h0;
  logic [7:0]  dn_data = 8'h0;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_data;
  logic        cpu_valid;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout = 8'h0;
  logic        core_reset;
  logic        dl_overflow;

  rom_dl_arbiter #(.AW(16), .HOLD_CYCLES(H), .ROM_TOP(TOP)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_valid(cpu_valid), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .core_reset(core_reset), .dl_overflow(dl_overflow)
  );

  typedef struct {int c; logic [15:0] a; logic [7:0] d;} ev_t;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   fails = 0;
  ev_t  wq[$];
  ev_t  vq[$];
  ev_t  ewq[$];
  ev_t  erq[$];

  bit        env_wr [0:65535];
  logic [7:0] env_mem [0:65535];
  bit        model_wr [0:65535];
  logic [7:0] model_mem [0:65535];

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    return model_wr[a] ? model_mem[a] : pattern(a);
  endfunction

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM seen by the DUT.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      env_mem[ram_addr] <= ram_din;
      env_wr[ram_addr]  <= 1'b1;
    end
    ram_dout <= env_wr[ram_addr] ? env_mem[ram_addr] : pattern(ram_addr);
  end

  always @(negedge CLK) begin
    if (ram_we)    wq.push_back('{c: cyc, a: ram_addr, d: ram_din});
    if (cpu_valid) vq.push_back('{c: cyc, a: 16'h0, d: cpu_data});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input int idx, input int exp_c,
                           input logic [15:0] a, input logic [7:0] d);
    chk({tag, "_cyc"},  (wq.size() > idx) ? wq[idx].c : -1, exp_c);
    chk({tag, "_addr"}, (wq.size() > idx) ? {16'h0, wq[idx].a} : 32'hFFFF_FFFF, {16'h0, a});
    chk({tag, "_data"}, (wq.size() > idx) ? {24'h0, wq[idx].d} : 32'hFFFF_FFFF, {24'h0, d});
  endtask

  task automatic do_read(input string tag, input logic [15:0] a);
    int k, v;
    cpu_req  = 1'b1;
    cpu_addr = a;
    k = cyc;
    v = vq.size();
    tick;
    cpu_req = 1'b0;
    tick;
    tick;
    chk({tag, "_cyc"},  (vq.size() > v) ? vq[v].c : -1, k + 2);
    chk({tag, "_data"}, (vq.size() > v) ? {24'h0, vq[v].d} : 32'hFFFF_FFFF, {24'h0, model_rd(a)});
  endtask

  task automatic wait_release(input string tag, input int exp_n);
    int n;
    n = 0;
    while (core_reset && n < 4 * H) begin
      tick;
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  int          n, k, v, n0, v0, lat, last_wr, last_rd;
  logic [15:0] a, b, x, a2;
  logic [7:0]  da, db;
  logic [15:0] a3 [3];
  logic [7:0]  d3 [3];

  initial begin
    a3[0] = 16'h0000; a3[1] = 16'h0001; a3[2] = 16'hBFFF;
    d3[0] = 8'h3E;    d3[1] = 8'hA5;    d3[2] = 8'h77;

    // Reset values while RESET_N is low.
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cpu_valid", cpu_valid, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_overflow", dl_overflow, 0);
    tick;
    tick;
    RESET_N = 1'b1;

    // Reset-to-run: IDLE plus the hold period.
    n = 0;
    while (core_reset && n < 4 * H) begin
      n++;
      tick;
    end
    chk("reset_hold_len", n, H + 1);
    chk("reset_no_write", wq.size(), 0);

    // Basic download.
    dn_download = 1'b1;
    tick;
    chk("load_core_reset", core_reset, 1);
    for (int i = 0; i < 3; i++) begin
      n = wq.size();
      dn_wr = 1'b1; dn_addr = a3[i]; dn_data = d3[i];
      k = cyc;
      tick;
      dn_wr = 1'b0;
      tick; tick; tick;
      chk_write("dl_byte", n, k + 1, a3[i], d3[i]);
      chk("dl_one_write", wq.size(), n + 1);
      chk("dl_core_reset", core_reset, 1);
      model_mem[a3[i]] = d3[i];
      model_wr[a3[i]]  = 1'b1;
    end
    dn_download = 1'b0;
    wait_release("drain_release", H + 2);

    // Writes in RUN are ignored; download content reads back.
    n = wq.size();
    dn_wr = 1'b1; dn_addr = 16'($urandom_range(0, 32'hBFFF)); dn_data = 8'($urandom);
    tick;
    dn_wr = 1'b0;
    tick; tick;
    chk("run_wr_ignored", wq.size(), n);
    chk("run_core_reset", core_reset, 0);
    for (int i = 0; i < 3; i++) do_read("run_readback", a3[i]);

    // Collision: read wins, write follows one cycle later.
    dn_download = 1'b1;
    tick; tick;
    n = wq.size(); v = vq.size(); k = cyc;
    dn_wr = 1'b1; dn_addr = 16'h1234; dn_data = 8'h5A;
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    #1;
    chk("col_rd_addr", ram_addr, 16'h0100);
    chk("col_rd_we", ram_we, 0);
    tick;
    dn_wr = 1'b0; cpu_req = 1'b0;
    tick; tick;
    chk_write("col_write", n, k + 1, 16'h1234, 8'h5A);
    chk("col_rd_cyc", (vq.size() > v) ? vq[v].c : -1, k + 2);
    chk("col_rd_data", (vq.size() > v) ? {24'h0, vq[v].d} : 32'hFFFF_FFFF, {24'h0, model_rd(16'h0100)});
    chk("col_no_overflow", dl_overflow, 0);
    model_mem[16'h1234] = 8'h5A; model_wr[16'h1234] = 1'b1;

    // Overflow: consecutive writes while reads hold the port.
    a  = 16'($urandom_range(0, 32'hBFFF)); da = 8'($urandom);
    b  = 16'($urandom_range(0, 32'hBFFF)); db = 8'($urandom);
    x  = 16'hC000 | 16'($urandom_range(0, 32'h3FFF));
    n = wq.size(); v = vq.size(); k = cyc;
    dn_wr = 1'b1; dn_addr = a; dn_data = da; cpu_req = 1'b1; cpu_addr = x;
    tick;
    dn_addr = b; dn_data = db;
    tick;
    dn_wr = 1'b0; cpu_req = 1'b0;
    chk("ovf_set", dl_overflow, 1);
    tick; tick; tick; tick;
    chk_write("ovf_first", n, k + 2, a, da);
    chk("ovf_second_dropped", wq.size(), n + 1);
    chk("ovf_sticky", dl_overflow, 1);
    chk("ovf_rd0_cyc", (vq.size() > v) ? vq[v].c : -1, k + 2);
    chk("ovf_rd1_cyc", (vq.size() > v + 1) ? vq[v+1].c : -1, k + 3);
    chk("ovf_rd1_data", (vq.size() > v + 1) ? {24'h0, vq[v+1].d} : 32'hFFFF_FFFF, {24'h0, model_rd(x)});
    model_mem[a] = da; model_wr[a] = 1'b1;

    // Out-of-range writes during LOAD.
    for (int i = 0; i < 2; i++) begin
      n = wq.size();
      dn_wr = 1'b1;
      dn_addr = (i == 0) ? 16'hC000 : 16'($urandom_range(32'hC000, 32'hFFFF));
      dn_data = 8'($urandom);
      tick;
      dn_wr = 1'b0;
      tick; tick; tick;
      chk("oor_no_write", wq.size(), n);
    end

    // Re-download during HOLD clears the overflow flag.
    dn_download = 1'b0;
    tick; tick; tick;
    chk("hold_core_reset", core_reset, 1);
    chk("hold_ovf_sticky", dl_overflow, 1);
    dn_download = 1'b1;
    tick;
    chk("redl_ovf_cleared", dl_overflow, 0);
    tick;

    // Randomized download traffic, longer than the hold period.
    n0 = wq.size(); v0 = vq.size();
    last_wr = -10; last_rd = -10;
    for (int i = 0; i < 200; i++) begin
      dn_wr = 1'b0; cpu_req = 1'b0;
      if (cyc >= last_wr + 2 && $urandom_range(0, 2) == 0) begin
        dn_wr   = 1'b1;
        dn_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32'hC000, 32'hFFFF))
                                              : 16'($urandom_range(0, 32'hBFFF));
        dn_data = 8'($urandom);
        last_wr = cyc;
        if (dn_addr <= TOP) ewq.push_back('{c: cyc, a: dn_addr, d: dn_data});
      end
      if (cyc >= last_rd + 4 && $urandom_range(0, 3) == 0) begin
        cpu_req  = 1'b1;
        cpu_addr = 16'hC000 | 16'($urandom_range(0, 32'h3FFF));
        last_rd  = cyc;
        erq.push_back('{c: cyc + 2, a: cpu_addr, d: model_rd(cpu_addr)});
      end
      tick;
    end
    dn_wr = 1'b0; cpu_req = 1'b0;
    tick; tick; tick; tick;
    chk("rnd_write_count", wq.size() - n0, ewq.size());
    for (int j = 0; j < ewq.size() && n0 + j < wq.size(); j++) begin
      lat = wq[n0+j].c - ewq[j].c;
      chk("rnd_write_addr", wq[n0+j].a, ewq[j].a);
      chk("rnd_write_data", wq[n0+j].d, ewq[j].d);
      chk("rnd_write_latency_1_or_2", (lat >= 1 && lat <= 2), 1);
      model_mem[ewq[j].a] = ewq[j].d;
      model_wr[ewq[j].a]  = 1'b1;
    end
    chk("rnd_read_count", vq.size() - v0, erq.size());
    for (int j = 0; j < erq.size() && v0 + j < vq.size(); j++) begin
      chk("rnd_read_cyc", vq[v0+j].c, erq[j].c);
      chk("rnd_read_data", vq[v0+j].d, erq[j].d);
    end
    chk("rnd_no_overflow", dl_overflow, 0);
    chk("rnd_hold_aborted", core_reset, 1);

    // Async reset while a write sits in the buffer.
    a2 = 16'($urandom_range(0, 32'hBFFF));
    n = wq.size();
    dn_wr = 1'b1; dn_addr = a2; dn_data = ~model_rd(a2);
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    tick;
    dn_wr = 1'b0;
    RESET_N = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("arst_ram_we", ram_we, 0);
    chk("arst_core_reset", core_reset, 1);
    chk("arst_cpu_valid", cpu_valid, 0);
    chk("arst_cpu_data", cpu_data, 0);
    chk("arst_overflow", dl_overflow, 0);
    tick; tick;
    RESET_N = 1'b1;
    tick; tick; tick; tick;
    chk("arst_buf_discarded", wq.size(), n);
    dn_download = 1'b0;
    wait_release("arst_release", H + 2);

    do_read("final_rd_a", a);
    do_read("final_rd_top", 16'hBFFF);
    do_read("final_rd_col", 16'h1234);
    do_read("final_rd_discarded", a2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
